// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate-multiplier driver.
package approx_mult_pkg;

  // Driver FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Latency counter width: clog2(lat), never narrower than one bit (lat=1 still needs a counter).
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/approx_err_absdiff.sv
// Combinational unsigned absolute difference |x - y| at width W.
module approx_err_absdiff #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] d
);

  // Subtract the smaller from the larger so the magnitude never wraps.
  always_comb begin
    d = (x >= y) ? (x - y) : (y - x);
  end

endmodule

// File: rtl/approx_mult_driver.sv
// Issues operand pairs to the approximate multiplier, waits its fixed latency,
// captures Z and reports it alongside the exact product and absolute error.
module approx_mult_driver
  import approx_mult_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             mul_load,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N:0]     mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N:0]     out_z,
  output logic [2*N-1:0]   out_exact,
  output logic [2*N:0]     out_err,
  output logic             busy
);

  localparam int CW = cnt_width(LAT);
  localparam int ZW = 2 * N + 1;

  state_t            state_reg;
  state_t            state_next;
  logic [CW-1:0]     cnt_reg;
  logic [N-1:0]      a_reg;
  logic [N-1:0]      b_reg;
  logic [ZW-1:0]     z_reg;
  logic [2*N-1:0]    exact_reg;
  logic [ZW-1:0]     err_reg;
  logic [2*N-1:0]    exact_next;
  logic [ZW-1:0]     err_next;
  logic              accept;
  logic              capture;

  // Exact reference product from the held operands (zero-extended so nothing truncates).
  assign exact_next = {{N{1'b0}}, a_reg} * {{N{1'b0}}, b_reg};

  approx_err_absdiff #(.W(ZW)) u_err (
    .x (mul_z),
    .y ({1'b0, exact_next}),
    .d (err_next)
  );

  assign accept  = (state_reg == IDLE) && in_valid;
  assign capture = (state_reg == WAIT) && (cnt_reg == '0);

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = ISSUE;
      ISSUE:                  state_next = WAIT;
      WAIT:    if (capture)   state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Latency counter: loaded on the load cycle, counts down to the capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == ISSUE) begin
      cnt_reg <= CW'(LAT - 1);
    end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Operand registers change only on the accept edge, so they stay stable through HOLD and after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
    end
  end

  // Result registers: approximate Z, exact product and error captured together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_reg     <= '0;
      exact_reg <= '0;
      err_reg   <= '0;
    end else if (capture) begin
      z_reg     <= mul_z;
      exact_reg <= exact_next;
      err_reg   <= err_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign mul_load  = (state_reg == ISSUE);
  assign out_valid = (state_reg == HOLD);
  assign mul_a     = a_reg;
  assign mul_b     = b_reg;
  assign out_z     = z_reg;
  assign out_exact = exact_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_approx_mult_driver.sv
// Directed self-checking bench for approx_mult_driver (LAT=4 main instance, LAT=1 throughput instance).
module tb_approx_mult_driver;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int ZW  = 2 * N + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Main instance (LAT=4)
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    in_a = '0;
  logic [N-1:0]    in_b = '0;
  logic            mul_load;
  logic [N-1:0]    mul_a;
  logic [N-1:0]    mul_b;
  logic [ZW-1:0]   mul_z;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [ZW-1:0]   out_z;
  logic [2*N-1:0]  out_exact;
  logic [ZW-1:0]   out_err;
  logic            busy;

  // Multiplier model: exact product, or a forced approximate value, delayed by LAT edges.
  logic            approx_en  = 1'b0;
  logic [ZW-1:0]   approx_val = '0;
  logic [ZW-1:0]   pipe [LAT];

  always @(posedge clk) begin
    pipe[0] <= mul_load ? (approx_en ? approx_val : {1'b0, {4'b0, mul_a} * {4'b0, mul_b}}) : '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_z = pipe[LAT-1];

  approx_mult_driver #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_exact(out_exact), .out_err(out_err), .busy(busy)
  );

  // Second instance (LAT=1) for the throughput check
  logic            in_valid1 = 1'b0;
  logic            in_ready1;
  logic [N-1:0]    in_a1 = '0;
  logic [N-1:0]    in_b1 = '0;
  logic            mul_load1;
  logic [N-1:0]    mul_a1;
  logic [N-1:0]    mul_b1;
  logic [ZW-1:0]   mul_z1 = '0;
  logic            out_valid1;
  logic            out_ready1 = 1'b0;
  logic [ZW-1:0]   out_z1;
  logic [2*N-1:0]  out_exact1;
  logic [ZW-1:0]   out_err1;
  logic            busy1;

  always @(posedge clk) begin
    mul_z1 <= mul_load1 ? {1'b0, {4'b0, mul_a1} * {4'b0, mul_b1}} : '0;
  end

  approx_mult_driver #(.N(N), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .mul_load(mul_load1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_z(mul_z1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_z(out_z1), .out_exact(out_exact1), .out_err(out_err1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and wait for it to be accepted; returns the accept edge number.
  task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b,
                           output int acc, output bit ok);
    bit got;
    got = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    acc = cyc;
    ok = got;
  endtask

  // Wait (bounded) for out_valid; returns the edge number where it was first seen.
  task automatic wait_valid(output int vcyc, output bit ok);
    ok = 1'b0;
    vcyc = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        vcyc = cyc;
      end else begin
        step();
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 4'hF;
    in_b = 4'hF;
    repeat (5) step();
    checks++;
    if ({in_ready, busy, mul_load, out_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl: got ready/busy/load/valid=%b required 1000",
               {in_ready, busy, mul_load, out_valid});
    end
    checks++;
    if ({out_z, out_exact, out_err, mul_a, mul_b} !== '0) begin
      failures++;
      $display("FAIL reset_data: got z=%h exact=%h err=%h a=%h b=%h required all 0",
               out_z, out_exact, out_err, mul_a, mul_b);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    $display("reset: 5 cycles held, in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_exact();
    int acc, loads, load_cyc, vcyc;
    bit ok;
    approx_en = 1'b0;
    send_pair(4'hF, 4'hF, acc, ok);
    loads = 0;
    load_cyc = -1;
    vcyc = -1;
    for (int i = 0; i < 20 && vcyc < 0; i++) begin
      if (mul_load) begin
        loads++;
        if (load_cyc < 0) load_cyc = cyc;
      end
      if (out_valid) vcyc = cyc;
      else step();
    end
    checks++;
    if (!ok || loads != 1 || load_cyc != acc) begin
      failures++;
      $display("FAIL exact_load: got loads=%0d at edge %0d required 1 at edge %0d",
               loads, load_cyc, acc);
    end
    checks++;
    if (vcyc != acc + 5) begin
      failures++;
      $display("FAIL exact_latency: got out_valid at edge %0d required %0d", vcyc, acc + 5);
    end
    checks++;
    if (out_z !== 9'h0E1 || out_exact !== 8'hE1 || out_err !== 9'h000) begin
      failures++;
      $display("FAIL exact_data: got z=%h exact=%h err=%h required 0e1/e1/000",
               out_z, out_exact, out_err);
    end
    $display("exact: F*F accept=%0d valid=%0d z=%h exact=%h err=%h", acc, vcyc, out_z, out_exact, out_err);
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL exact_release: got valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_approx();
    logic [ZW-1:0] zv  [3];
    logic [ZW-1:0] erv [3];
    int acc, vcyc;
    bit ok1, ok2;
    zv[0] = 9'h0E0; erv[0] = 9'h001;
    zv[1] = 9'h0E3; erv[1] = 9'h002;
    zv[2] = 9'h100; erv[2] = 9'h01F;
    for (int k = 0; k < 3; k++) begin
      approx_en = 1'b1;
      approx_val = zv[k];
      send_pair(4'hF, 4'hF, acc, ok1);
      wait_valid(vcyc, ok2);
      checks++;
      if (!ok1 || !ok2 || out_z !== zv[k] || out_err !== erv[k] || out_exact !== 8'hE1) begin
        failures++;
        $display("FAIL approx_%0d: got z=%h exact=%h err=%h required z=%h exact=e1 err=%h",
                 k, out_z, out_exact, out_err, zv[k], erv[k]);
      end
      $display("approx: model z=%h -> out_err=%h", zv[k], out_err);
      release_result();
    end
    approx_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc, vcyc, bad;
    bit ok1, ok2;
    send_pair(4'h5, 4'h6, acc, ok1);
    wait_valid(vcyc, ok2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 4'h3;
      in_b = 4'h3;
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_exact !== 8'h1E || out_z !== 9'h01E
          || out_err !== 9'h000 || mul_a !== 4'h5 || mul_b !== 4'h6) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok1 || !ok2 || bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold: got %0d unstable cycles (exact=%h a=%h b=%h) required 0 with exact=1e a=5 b=6",
               bad, out_exact, mul_a, mul_b);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_a !== 4'h5 || mul_b !== 4'h6) begin
      failures++;
      $display("FAIL backpressure_release: got valid=%b ready=%b a=%h b=%h required 0/1/5/6",
               out_valid, in_ready, mul_a, mul_b);
    end
    $display("backpressure: 10 stalled cycles, result exact=%h held", out_exact);
  endtask

  task automatic test_async_reset();
    int acc, vcyc;
    bit ok1, ok2;
    send_pair(4'hF, 4'hF, acc, ok1);
    wait_valid(vcyc, ok2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!ok1 || !ok2 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0
        || {out_z, out_exact, out_err, mul_a, mul_b} !== '0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b ready=%b busy=%b z=%h exact=%h a=%h required cleared before edge",
               out_valid, in_ready, busy, out_z, out_exact, mul_a);
    end
    #2 rst = 1'b0;
    step();
    $display("async_reset: outputs cleared mid-cycle");
  endtask

  task automatic test_reset_wait();
    int acc, vcyc, bad;
    bit ok1, ok2;
    send_pair(4'h9, 4'h9, acc, ok1);
    step();
    step();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid || mul_load || busy) bad++;
    end
    checks++;
    if (!ok1 || bad != 0) begin
      failures++;
      $display("FAIL reset_wait_abort: got %0d cycles with valid/load/busy required 0", bad);
    end
    send_pair(4'h2, 4'h6, acc, ok1);
    wait_valid(vcyc, ok2);
    checks++;
    if (!ok1 || !ok2 || out_exact !== 8'h0C || out_z !== 9'h00C || out_err !== 9'h000) begin
      failures++;
      $display("FAIL reset_wait_next: got exact=%h z=%h err=%h required 0c/00c/000",
               out_exact, out_z, out_err);
    end
    $display("reset_wait: aborted 9*9, next 2*6 exact=%h", out_exact);
    release_result();
  endtask

  task automatic test_back_to_back();
    int acc_c [2];
    logic [2*N-1:0] res [2];
    int acc_n, res_n;
    bit acc;
    // LAT=4 instance
    acc_n = 0; res_n = 0;
    out_ready = 1'b1;
    in_a = 4'h3; in_b = 4'h5; in_valid = 1'b1;
    for (int i = 0; i < 60 && res_n < 2; i++) begin
      acc = in_valid && in_ready;
      step();
      if (acc && acc_n < 2) begin
        acc_c[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) begin in_a = 4'h0; in_b = 4'h7; end
        else in_valid = 1'b0;
      end
      if (out_valid && res_n < 2) begin res[res_n] = out_exact; res_n++; end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (acc_n != 2 || acc_c[1] - acc_c[0] != 7) begin
      failures++;
      $display("FAIL b2b_spacing_lat4: got %0d accepts spaced %0d required 2 spaced 7",
               acc_n, (acc_n == 2) ? acc_c[1] - acc_c[0] : -1);
    end
    checks++;
    if (res_n != 2 || res[0] !== 8'h0F || res[1] !== 8'h00) begin
      failures++;
      $display("FAIL b2b_results_lat4: got %0d results %h %h required 0f 00", res_n, res[0], res[1]);
    end
    $display("back_to_back LAT=4: accepts at %0d,%0d exact %h,%h", acc_c[0], acc_c[1], res[0], res[1]);
    step();
    // LAT=1 instance
    acc_n = 0; res_n = 0;
    res[0] = 'x; res[1] = 'x;
    out_ready1 = 1'b1;
    in_a1 = 4'h3; in_b1 = 4'h5; in_valid1 = 1'b1;
    for (int i = 0; i < 60 && res_n < 2; i++) begin
      acc = in_valid1 && in_ready1;
      step();
      if (acc && acc_n < 2) begin
        acc_c[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) begin in_a1 = 4'h0; in_b1 = 4'h7; end
        else in_valid1 = 1'b0;
      end
      if (out_valid1 && res_n < 2) begin res[res_n] = out_exact1; res_n++; end
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    checks++;
    if (acc_n != 2 || acc_c[1] - acc_c[0] != 4) begin
      failures++;
      $display("FAIL b2b_spacing_lat1: got %0d accepts spaced %0d required 2 spaced 4",
               acc_n, (acc_n == 2) ? acc_c[1] - acc_c[0] : -1);
    end
    checks++;
    if (res_n != 2 || res[0] !== 8'h0F || res[1] !== 8'h00) begin
      failures++;
      $display("FAIL b2b_results_lat1: got %0d results %h %h required 0f 00", res_n, res[0], res[1]);
    end
    $display("back_to_back LAT=1: accepts at %0d,%0d exact %h,%h", acc_c[0], acc_c[1], res[0], res[1]);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_backpressure();
    test_async_reset();
    test_reset_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
